fft_out_serializer: RTL and testbench



---
 rtl/fft_out_serializer.sv | 121 ++++++++++++
 tb/tb_fft_out_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_serializer.sv
// Purpose: capture one N-point parallel FFT frame (4 lanes/beat) and replay it as a serial {re,im} stream.
// Latency: first sample valid the cycle after the last capture beat; outputs registered, one sample/cycle.
// Backpressure: valid/ready, sample held stable while i_ready low; beats arriving while draining are dropped (sticky o_overflow).
// Optional: define FFT_OUT_SERIALIZER_BITREV_EN to drain in bit-reversed bin order.
module fft_out_serializer #(
    parameter int NBITS = 10,
    parameter int N     = 32,
    parameter int LOGN  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_enable,
    input  logic [NBITS*2-1:0]   fftIn0_up,
    input  logic [NBITS*2-1:0]   fftIn0_down,
    input  logic [NBITS*2-1:0]   fftIn1_up,
    input  logic [NBITS*2-1:0]   fftIn1_down,
    output logic [NBITS*2-1:0]   o_data,
    output logic [LOGN-1:0]      o_index,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_overflow
);
    localparam int W     = NBITS * 2;
    localparam int DEPTH = N / 4;
    localparam int AW    = LOGN - 2;

    typedef enum logic {CAPTURE, DRAIN} state_t;

    state_t          state;
    logic [AW-1:0]   beat;      // capture beat count k
    logic [LOGN-1:0] seq;       // drain position r (handshakes so far)
    logic [W-1:0]    bank [4][DEPTH];

    logic            take;
    logic            hs;
    logic [LOGN-1:0] seq_nxt;
    logic [LOGN-1:0] bin_nxt;
    logic [W-1:0]    dat_nxt;

    assign take = in_enable && (state == CAPTURE);
    assign hs   = o_valid && i_ready;

    // Next drain position and the bin/sample it selects (upper two bits pick the bank).
    always_comb begin
        seq_nxt = (state == CAPTURE) ? '0 : seq + LOGN'(1);
`ifdef FFT_OUT_SERIALIZER_BITREV_EN
        bin_nxt = '0;
        for (int b = 0; b < LOGN; b++) begin
            bin_nxt[b] = seq_nxt[LOGN-1-b];
        end
`else
        bin_nxt = seq_nxt;
`endif
        dat_nxt = bank[bin_nxt[LOGN-1 -: 2]][bin_nxt[AW-1:0]];
    end

    // Lane storage: each capture beat writes all four banks at address k; contents are not reset.
    always_ff @(posedge clk) begin
        if (take) begin
            bank[0][beat] <= fftIn0_up;
            bank[1][beat] <= fftIn0_down;
            bank[2][beat] <= fftIn1_up;
            bank[3][beat] <= fftIn1_down;
        end
    end

    // Capture/drain sequencing with registered stream outputs and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CAPTURE;
            beat       <= '0;
            seq        <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_index    <= '0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (in_enable && (state == DRAIN)) begin
                o_overflow <= 1'b1;
            end
            case (state)
                CAPTURE: begin
                    if (in_enable) begin
                        beat <= beat + AW'(1);
                        if (beat == AW'(DEPTH - 1)) begin
                            state   <= DRAIN;
                            seq     <= '0;
                            o_valid <= 1'b1;
                            o_data  <= dat_nxt;
                            o_index <= bin_nxt;
                            o_sof   <= 1'b1;
                            o_eof   <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (&seq) begin
                            state   <= CAPTURE;
                            seq     <= '0;
                            o_valid <= 1'b0;
                            o_sof   <= 1'b0;
                            o_eof   <= 1'b0;
                        end else begin
                            seq     <= seq_nxt;
                            o_data  <= dat_nxt;
                            o_index <= bin_nxt;
                            o_sof   <= 1'b0;
                            o_eof   <= &seq_nxt;
                        end
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: frame-level queue model of capture and drain order.
// Latency: model advances once per clock, checked half a cycle after each edge.
// Backpressure: random and patterned i_ready, overflow pulses while draining.
module tb_fft_out_serializer;
    localparam int NBITS = 10;
    localparam int N     = 32;
    localparam int LOGN  = 5;
    localparam int W     = NBITS * 2;
    localparam int Q     = N / 4;

`ifdef FFT_OUT_SERIALIZER_BITREV_EN
    localparam int EXP1 = 16;
    localparam int EXP2 = 8;
    localparam int EXP3 = 24;
    localparam int EXP5 = 20;
`else
    localparam int EXP1 = 1;
    localparam int EXP2 = 2;
    localparam int EXP3 = 3;
    localparam int EXP5 = 5;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_enable;
    logic [W-1:0]    fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down;
    logic [W-1:0]    o_data;
    logic [LOGN-1:0] o_index;
    logic            o_valid, i_ready, o_sof, o_eof, o_overflow;

    fft_out_serializer #(.NBITS(NBITS), .N(N), .LOGN(LOGN)) dut (
        .clk(clk), .rst(rst), .in_enable(in_enable),
        .fftIn0_up(fftIn0_up), .fftIn0_down(fftIn0_down),
        .fftIn1_up(fftIn1_up), .fftIn1_down(fftIn1_down),
        .o_data(o_data), .o_index(o_index), .o_valid(o_valid), .i_ready(i_ready),
        .o_sof(o_sof), .o_eof(o_eof), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOGN-1:0] idx;
        logic [W-1:0]    dat;
        logic            sof;
        logic            eof;
    } smp_t;

    int           vectors = 0;
    int           miscompares = 0;
    smp_t         expq[$];
    logic [W-1:0] mframe [N];
    int           mk = 0;
    logic         movf = 1'b0;
    int           hs_log[$];
    logic [W-1:0] dlog[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int drain_bin(int i);
        int r;
        r = i;
`ifdef FFT_OUT_SERIALIZER_BITREV_EN
        r = 0;
        for (int b = 0; b < LOGN; b++) begin
            if (i[b]) r = r | (1 << (LOGN - 1 - b));
        end
`endif
        return r;
    endfunction

    // One clock: compare outputs against the model at the falling edge, then advance the model
    // with the inputs the next rising edge will consume, then return just after that edge.
    task automatic tick();
        @(negedge clk);
        chk("o_valid", o_valid, expq.size() > 0);
        if (expq.size() > 0) begin
            chk("o_index", o_index, expq[0].idx);
            chk("o_data", o_data, expq[0].dat);
            chk("o_sof", o_sof, expq[0].sof);
            chk("o_eof", o_eof, expq[0].eof);
        end else begin
            chk("o_sof_idle", o_sof, 0);
            chk("o_eof_idle", o_eof, 0);
        end
        chk("o_overflow", o_overflow, movf);
        if (!rst && o_valid && i_ready) begin
            hs_log.push_back(int'(o_index));
            dlog.push_back(o_data);
        end
        if (rst) begin
            expq.delete();
            mk   = 0;
            movf = 1'b0;
        end else if (expq.size() > 0) begin
            if (in_enable) movf = 1'b1;
            if (i_ready) void'(expq.pop_front());
        end else if (in_enable) begin
            mframe[mk]       = fftIn0_up;
            mframe[mk + Q]   = fftIn0_down;
            mframe[mk + 2*Q] = fftIn1_up;
            mframe[mk + 3*Q] = fftIn1_down;
            mk++;
            if (mk == Q) begin
                mk = 0;
                for (int i = 0; i < N; i++) begin
                    smp_t s;
                    int   b;
                    b     = drain_bin(i);
                    s.idx = LOGN'(b);
                    s.dat = mframe[b];
                    s.sof = (i == 0);
                    s.eof = (i == N - 1);
                    expq.push_back(s);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(int k, bit pattern);
        logic [W-1:0]     v [4];
        logic [NBITS-1:0] bb;
        for (int l = 0; l < 4; l++) begin
            bb   = NBITS'(k + l * Q);
            v[l] = pattern ? {bb, ~bb} : W'($urandom);
        end
        fftIn0_up   = v[0];
        fftIn0_down = v[1];
        fftIn1_up   = v[2];
        fftIn1_down = v[3];
    endtask

    task automatic send_frame(int nbeats, bit pattern, int maxgap);
        for (int k = 0; k < nbeats; k++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            in_enable = 1'b0;
            for (int g = 0; g < gap; g++) begin
                set_lanes(k, 1'b0);
                tick();
            end
            set_lanes(k, pattern);
            in_enable = 1'b1;
            i_ready   = 1'($urandom_range(1, 0));
            tick();
        end
        in_enable = 1'b0;
    endtask

    task automatic drain(int rmode, int ovf_at);
        int c;
        c = 0;
        while (expq.size() > 0 && c < 400) begin
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = (c % 3 == 0);
                default: i_ready = 1'($urandom_range(1, 0));
            endcase
            in_enable = (c == ovf_at);
            set_lanes(c % Q, 1'b0);
            tick();
            c++;
        end
        in_enable = 1'b0;
        i_ready   = 1'b1;
        chk("drain_done", expq.size(), 0);
        tick();
    endtask

    initial begin
        logic [NBITS-1:0] b5;
        rst = 1'b1; in_enable = 1'b0; i_ready = 1'b1;
        set_lanes(0, 1'b1);
        tick(); tick(); tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_index", o_index, 0);
        chk("rst_sof", o_sof, 0);
        chk("rst_eof", o_eof, 0);
        chk("rst_ovf", o_overflow, 0);
        rst = 1'b0;
        tick();

        // Directed frame, back to back, ready always high
        hs_log.delete(); dlog.delete();
        send_frame(Q, 1'b1, 0);
        chk("t1_valid_rise", o_valid, 1);
        chk("t1_first_sof", o_sof, 1);
        drain(0, -1);
        chk("t1_count", hs_log.size(), N);
        chk("t1_idx0", hs_log[0], 0);
        chk("t1_idx1", hs_log[1], EXP1);
        chk("t1_idx2", hs_log[2], EXP2);
        chk("t1_idx3", hs_log[3], EXP3);
        chk("t1_idx31", hs_log[31], 31);
        b5 = NBITS'(EXP5);
        chk("t1_data5", dlog[5], {b5, ~b5});

        // Same pattern with random gaps between beats
        hs_log.delete();
        send_frame(Q, 1'b1, 3);
        drain(0, -1);
        chk("t2_count", hs_log.size(), N);

        // Ready toggling 1,0,0
        hs_log.delete();
        send_frame(Q, 1'b0, 2);
        drain(1, -1);
        chk("t3_count", hs_log.size(), N);

        // Overflow pulse while draining, then a clean frame
        send_frame(Q, 1'b0, 1);
        drain(2, 7);
        chk("t4_ovf_sticky", o_overflow, 1);
        send_frame(Q, 1'b0, 0);
        drain(0, -1);
        chk("t4_ovf_still", o_overflow, 1);

        // Reset after a partial frame
        send_frame(4, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", o_valid, 0);
        chk("t5_ovf", o_overflow, 0);
        hs_log.delete();
        send_frame(Q, 1'b1, 0);
        drain(0, -1);
        chk("t5_count", hs_log.size(), N);
        chk("t5_first", hs_log[0], 0);

        // Random frames, random ready, random dropped beats
        for (int f = 0; f < 6; f++) begin
            send_frame(Q, 1'b0, 3);
            drain(2, ($urandom_range(1, 0) != 0) ? int'($urandom_range(40, 0)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
